// File: rtl/execute_vector_mc_pkg.sv
// Shared types and helpers for the beat-serial vector execute stage.
package vexec_pkg;

  typedef enum logic [2:0] {
    VOP_ADD   = 3'b000,
    VOP_SUB   = 3'b001,
    VOP_AND   = 3'b010,
    VOP_OR    = 3'b011,
    VOP_XOR   = 3'b100,
    VOP_SHL   = 3'b101,
    VOP_SHR   = 3'b110,
    VOP_PASSB = 3'b111
  } vop_e;

  typedef enum logic [1:0] {
    VS_IDLE = 2'b00,
    VS_RUN  = 2'b01,
    VS_DONE = 2'b10
  } vstate_e;

  typedef enum logic [1:0] {
    VFWD_VRD  = 2'b00,
    VFWD_WB   = 2'b01,
    VFWD_MEM  = 2'b10,
    VFWD_ZERO = 2'b11
  } vfwd_e;

  // Number of beats needed to sweep a V-bit vector with P lanes of E bits.
  function automatic int beats(input int v, input int e, input int p);
    return v / (e * p);
  endfunction

endpackage

// File: rtl/execute_vector_mc_if.sv
// Decode/Memory-facing bundle of the vector execute stage.
interface execute_vector_mc_if #(
  parameter int V = 256,
  parameter int R = 5
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ALUControlE;
  logic [V-1:0] VRD1E;
  logic [V-1:0] VRD2E;
  logic [V-1:0] ResultVW;
  logic [V-1:0] ALUResultVM;
  logic [1:0]   ForwardAVE;
  logic [1:0]   ForwardBVE;
  logic [R-1:0] WA3Ei;
  logic         RegWriteVEi;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [V-1:0] ALUResultVE;
  logic [V-1:0] WriteDataVE;
  logic [R-1:0] WA3Eo;
  logic         RegWriteVEo;
  logic         StallVE;

  // Pipeline side that issues ops and consumes results.
  modport master (
    output in_valid, ALUControlE, VRD1E, VRD2E, ResultVW, ALUResultVM,
           ForwardAVE, ForwardBVE, WA3Ei, RegWriteVEi, flush, out_ready,
    input  in_ready, out_valid, ALUResultVE, WriteDataVE, WA3Eo,
           RegWriteVEo, StallVE
  );

  // The execute unit itself.
  modport slave (
    input  in_valid, ALUControlE, VRD1E, VRD2E, ResultVW, ALUResultVM,
           ForwardAVE, ForwardBVE, WA3Ei, RegWriteVEi, flush, out_ready,
    output in_ready, out_valid, ALUResultVE, WriteDataVE, WA3Eo,
           RegWriteVEo, StallVE
  );
endinterface

// File: rtl/execute_vector_mc_alu.sv
// One element-wide lane ALU; arithmetic wraps within the element.
module vlane_alu
  import vexec_pkg::*;
#(
  parameter int E = 8
) (
  input  logic [E-1:0] a,
  input  logic [E-1:0] b,
  input  vop_e         op,
  output logic [E-1:0] y
);

  localparam int SW = $clog2(E);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  // Element operation select; only the low log2(E) bits of B shift.
  always_comb begin
    y = '0;
    case (op)
      VOP_ADD:   y = a + b;
      VOP_SUB:   y = a - b;
      VOP_AND:   y = a & b;
      VOP_OR:    y = a | b;
      VOP_XOR:   y = a ^ b;
      VOP_SHL:   y = a << shamt;
      VOP_SHR:   y = a >> shamt;
      VOP_PASSB: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/execute_vector_mc.sv
// Beat-serial vector execute stage: captures forwarded operands at accept,
// computes P elements per cycle, then holds the result until Memory takes it.
module execute_vector_mc
  import vexec_pkg::*;
#(
  parameter int V = 256,
  parameter int E = 8,
  parameter int P = 4,
  parameter int R = 5
) (
  input  logic                clk,
  input  logic                rst,
  execute_vector_mc_if.slave  bus
);

  localparam int BEATS = beats(V, E, P);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam bit PARAMS_OK = ((E == 8) || (E == 16) || (E == 32)) && ((V % (E * P)) == 0);

  generate
    if (!PARAMS_OK) begin : g_param_check
      $fatal(1, "execute_vector_mc: V must be a multiple of E*P and E one of 8/16/32");
    end
  endgenerate

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  vstate_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [V-1:0] a_q, a_d;
  logic [V-1:0] b_q, b_d;
  vop_e         op_q, op_d;
  logic [R-1:0] wa3_q, wa3_d;
  logic         regwr_q, regwr_d;
  logic [V-1:0] res_q, res_d;

  logic [V-1:0] a_sel, b_sel;
  logic [E-1:0] lane_y [P];

  // Forwarding muxes for both operands, live only in the accept cycle.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    case (vfwd_e'(bus.ForwardAVE))
      VFWD_VRD:  a_sel = bus.VRD1E;
      VFWD_WB:   a_sel = bus.ResultVW;
      VFWD_MEM:  a_sel = bus.ALUResultVM;
      default:   a_sel = '0;
    endcase
    case (vfwd_e'(bus.ForwardBVE))
      VFWD_VRD:  b_sel = bus.VRD2E;
      VFWD_WB:   b_sel = bus.ResultVW;
      VFWD_MEM:  b_sel = bus.ALUResultVM;
      default:   b_sel = '0;
    endcase
  end

  for (genvar g = 0; g < P; g++) begin : g_lane
    logic [E-1:0] lane_a, lane_b;
    assign lane_a = a_q[(int'(cnt_q) * P + g) * E +: E];
    assign lane_b = b_q[(int'(cnt_q) * P + g) * E +: E];
    vlane_alu #(.E(E)) u_alu (
      .a  (lane_a),
      .b  (lane_b),
      .op (op_q),
      .y  (lane_y[g])
    );
  end

  // Next-state logic: flush wins over accept and the output handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    wa3_d   = wa3_q;
    regwr_d = regwr_q;
    res_d   = res_q;
    if (bus.flush) begin
      state_d = VS_IDLE;
      regwr_d = 1'b0;
    end else begin
      case (state_q)
        VS_IDLE: begin
          if (bus.in_valid) begin
            a_d     = a_sel;
            b_d     = b_sel;
            op_d    = vop_e'(bus.ALUControlE);
            wa3_d   = bus.WA3Ei;
            regwr_d = bus.RegWriteVEi;
            cnt_d   = '0;
            state_d = VS_RUN;
          end
        end
        VS_RUN: begin
          for (int i = 0; i < P; i++) begin
            res_d[(int'(cnt_q) * P + i) * E +: E] = lane_y[i];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = VS_DONE;
          end
        end
        VS_DONE: begin
          if (bus.out_ready) begin
            state_d = VS_IDLE;
          end
        end
        default: state_d = VS_IDLE;
      endcase
    end
  end

  // All state and captured outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= VS_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= VOP_ADD;
      wa3_q   <= '0;
      regwr_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      wa3_q   <= wa3_d;
      regwr_q <= regwr_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready    = (state_q == VS_IDLE);
  assign bus.out_valid   = (state_q == VS_DONE);
  assign bus.ALUResultVE = res_q;
  assign bus.WriteDataVE = b_q;
  assign bus.WA3Eo       = wa3_q;
  assign bus.RegWriteVEo = regwr_q;
  assign bus.StallVE     = bus.in_valid & (state_q != VS_IDLE);

endmodule
